// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Purpose  : Bundle of requester and uart_tx-core signals around the shared
//            UART transmitter arbiter. The "slave" modport is the arbiter.
//            The "master" modport is the surrounding system, meaning the
//            report formatters plus the uart_tx core.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int N = 3
);
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ack;
  logic [N-1:0]   grant;
  logic           abort;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy;
  logic           tx_done;

  modport master (
    output req, req_data, req_last, tx_busy, tx_done,
    input  req_ack, grant, abort, tx_start, tx_data
  );

  modport slave (
    input  req, req_data, req_last, tx_busy, tx_done,
    output req_ack, grant, abort, tx_start, tx_data
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one uart_tx core between N report sources. A source owns
//            the transmitter for a whole message, which ends at the byte
//            flagged last. Ownership is revoked if the source stalls longer
//            than GAP_CYCLES. By default the next owner is picked round-robin.
//            Defining UART_ARB_FIXED_PRIO_EN selects the lowest requesting
//            index instead.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int N          = 3,
  parameter int GAP_CYCLES = 16,
  parameter int PTR_W      = 3
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int c_gap_w = $clog2(GAP_CYCLES + 1);
  localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_gidx;
  logic [N-1:0]       r_grant;
  logic [N-1:0]       r_ack;
  logic               r_start;
  logic               r_abort;
  logic [7:0]         r_data;
  logic               r_last;
  logic [c_gap_w-1:0] r_gap;

  logic               w_any;
  logic [PTR_W-1:0]   w_sel;
  logic [N-1:0]       w_sel_oh;
  logic               w_req_g;
  logic               w_last_g;
  logic [7:0]         w_data_g;
`ifndef UART_ARB_FIXED_PRIO_EN
  int                 w_dist;
  int                 w_best;
`endif

  // Pick the next owner among the active requests, in both index and one-hot form.
  always_comb begin
    w_any    = |bus.req;
    w_sel    = '0;
    w_sel_oh = '0;
`ifdef UART_ARB_FIXED_PRIO_EN
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req[i]) w_sel = PTR_W'(i);
    end
`else
    // Distance of index i from the slot just after the pointer, modulo N.
    // The smallest distance among the active requests wins.
    w_best = N;
    w_dist = 0;
    for (int i = 0; i < N; i++) begin
      w_dist = i + N - 1 - int'(r_ptr);
      if (w_dist >= N) w_dist = w_dist - N;
      if (bus.req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        w_sel  = PTR_W'(i);
      end
    end
`endif
    for (int i = 0; i < N; i++) begin
      w_sel_oh[i] = (w_sel == PTR_W'(i));
    end
  end

  // Use the one-hot grant as a mask to pick out the current owner's req, last flag and byte.
  always_comb begin
    w_req_g  = |(bus.req & r_grant);
    w_last_g = |(bus.req_last & r_grant);
    w_data_g = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) w_data_g = w_data_g | bus.req_data[8*i +: 8];
    end
  end

  // Message FSM. Every output is registered, and the pulse outputs default low each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_W'(N - 1);
      r_gidx  <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      r_data  <= 8'h00;
      r_last  <= 1'b0;
      r_gap   <= '0;
    end else begin
      r_ack   <= '0;
      r_start <= 1'b0;
      r_abort <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant <= w_sel_oh;
            r_gidx  <= w_sel;
            r_gap   <= '0;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_req_g) begin
            // A byte that is ready but blocked by a busy core does not count toward the gap.
            if (!bus.tx_busy) begin
              r_data  <= w_data_g;
              r_start <= 1'b1;
              r_ack   <= r_grant;
              r_last  <= w_last_g;
              r_gap   <= '0;
              r_state <= S_WAIT;
            end
          end else if (r_gap == c_gap_last) begin
            r_abort <= 1'b1;
            r_grant <= '0;
            r_ptr   <= r_gidx;
            r_state <= S_IDLE;
          end else begin
            r_gap <= r_gap + c_gap_w'(1);
          end
        end
        S_WAIT: begin
          if (bus.tx_done) begin
            if (r_last) begin
              r_grant <= '0;
              r_ptr   <= r_gidx;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_LOAD;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.grant    = r_grant;
  assign bus.req_ack  = r_ack;
  assign bus.tx_start = r_start;
  assign bus.abort    = r_abort;
  assign bus.tx_data  = r_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Directed self-checking bench for uart_tx_arbiter. It models the
//            requesters and a uart_tx core that sends one byte per ~10 cycles.
//            Expected (grant, byte) pairs go into a scoreboard queue and are
//            checked on every tx_start.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.N(N)) bus ();

  uart_tx_arbiter #(.N(N), .GAP_CYCLES(16), .PTR_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [2:0] grant;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];
  int checks    = 0;
  int failures  = 0;
  int start_cnt = 0;
  int abort_cnt = 0;

  // Requester model: source k presents byte (ack_cnt-base) of its message.
  // pause_at forces req low at that byte position.
  logic [7:0] msg_bytes [N][8];
  int msg_len  [N];
  int base     [N];
  int pause_at [N];
  int ack_cnt  [N];

  always_comb begin
    bus.req      = '0;
    bus.req_last = '0;
    bus.req_data = '0;
    for (int k = 0; k < N; k++) begin
      if ((ack_cnt[k] - base[k] < msg_len[k]) && (ack_cnt[k] - base[k] != pause_at[k]))
        bus.req[k] = 1'b1;
      if (ack_cnt[k] - base[k] == msg_len[k] - 1)
        bus.req_last[k] = 1'b1;
      bus.req_data[8*k +: 8] = msg_bytes[k][3'((ack_cnt[k] - base[k]) & 7)];
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (bus.req_ack[k]) ack_cnt[k] <= ack_cnt[k] + 1;
    end
  end

  // uart_tx core model: roughly 10 cycles per byte, then a one-cycle done pulse.
  logic core_busy  = 1'b0;
  logic core_done  = 1'b0;
  logic force_busy = 1'b0;
  logic stray_done = 1'b0;
  int   core_cnt   = 0;

  assign bus.tx_busy = core_busy | force_busy;
  assign bus.tx_done = core_done | stray_done;

  always @(posedge clk) begin
    if (!rst) begin
      core_busy <= 1'b0;
      core_done <= 1'b0;
      core_cnt  <= 0;
    end else begin
      core_done <= 1'b0;
      if (bus.tx_start) begin
        core_busy <= 1'b1;
        core_cnt  <= 9;
      end else if (core_cnt > 0) begin
        core_cnt <= core_cnt - 1;
        if (core_cnt == 1) begin
          core_busy <= 1'b0;
          core_done <= 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [7:0] d);
    exp_t e;
    e.grant = g;
    e.data  = d;
    sb.push_back(e);
  endtask

  task automatic load_msg(input int k, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2);
    msg_bytes[k][0] = b0;
    msg_bytes[k][1] = b1;
    msg_bytes[k][2] = b2;
    base[k]         = ack_cnt[k];
    msg_len[k]      = n;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (bus.abort) abort_cnt++;
        if (bus.tx_start) begin
          start_cnt++;
          chk("sb_has_entry", 32'(sb.size() != 0), 32'h1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_data", 32'(bus.tx_data), 32'(e.data));
            chk("sb_grant", 32'(bus.grant), 32'(e.grant));
            chk("sb_ack", 32'(bus.req_ack), 32'(e.grant));
          end
        end else begin
          chk("ack_without_start", 32'(bus.req_ack), 32'h0);
        end
      end
    end
  endtask

  task automatic wait_ack(input string tag, input int k, input int n);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (ack_cnt[k] - base[k] >= n) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'h1);
  endtask

  task automatic wait_done(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      if (bus.tx_done) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'h1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 600 && !ok; i++) begin
      @(negedge clk);
      if (bus.grant == '0 && bus.req == '0 && sb.size() == 0) ok = 1'b1;
    end
    chk(tag, 32'(ok), 32'h1);
  endtask

  initial begin
    int s0;
    for (int k = 0; k < N; k++) begin
      pause_at[k] = -1;
      msg_len[k]  = 0;
      base[k]     = 0;
      for (int j = 0; j < 8; j++) msg_bytes[k][j] = 8'h00;
    end
    fork
      monitor();
    join_none

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_ack", 32'(bus.req_ack), 32'h0);
    chk("rst_start", 32'(bus.tx_start), 32'h0);
    chk("rst_data", 32'(bus.tx_data), 32'h0);
    chk("rst_abort", 32'(bus.abort), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single three-byte message from source 1
    load_msg(1, 3, 8'h73, 8'h31, 8'h0A);
    push_exp(3'b010, 8'h73);
    push_exp(3'b010, 8'h31);
    push_exp(3'b010, 8'h0A);
    wait_ack("t1_acks_tmo", 1, 3);
    wait_done("t1_done_tmo");
    chk("t1_grant_at_done", 32'(bus.grant), 32'h2);
    @(negedge clk);
    chk("t1_grant_cleared", 32'(bus.grant), 32'h0);
    chk("t1_data_held", 32'(bus.tx_data), 32'h0A);
    chk("t1_ack_count", 32'(ack_cnt[1] - base[1]), 32'd3);

    // Simultaneous requests just after reset: order 0,1,2, with no interleaving
    rst = 1'b0;
    load_msg(0, 2, 8'hA0, 8'hA1, 8'h00);
    load_msg(1, 2, 8'hB0, 8'hB1, 8'h00);
    load_msg(2, 2, 8'hC0, 8'hC1, 8'h00);
    push_exp(3'b001, 8'hA0);
    push_exp(3'b001, 8'hA1);
    push_exp(3'b010, 8'hB0);
    push_exp(3'b010, 8'hB1);
    push_exp(3'b100, 8'hC0);
    push_exp(3'b100, 8'hC1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t2_first_grant", 32'(bus.grant), 32'h1);
    wait_idle("t2_idle_tmo");

    // Fairness: once source 1 has been served, 2 wins over 0 (fixed priority: 0 wins)
    load_msg(1, 1, 8'h55, 8'h00, 8'h00);
    push_exp(3'b010, 8'h55);
    wait_idle("t3a_idle_tmo");
    load_msg(0, 1, 8'h60, 8'h00, 8'h00);
    load_msg(2, 1, 8'h62, 8'h00, 8'h00);
`ifdef UART_ARB_FIXED_PRIO_EN
    push_exp(3'b001, 8'h60);
    push_exp(3'b100, 8'h62);
`else
    push_exp(3'b100, 8'h62);
    push_exp(3'b001, 8'h60);
`endif
    @(negedge clk);
`ifdef UART_ARB_FIXED_PRIO_EN
    chk("t3_grant", 32'(bus.grant), 32'h1);
`else
    chk("t3_grant", 32'(bus.grant), 32'h4);
`endif
    wait_idle("t3b_idle_tmo");

    // Gap of 16 cycles: abort, then the pending source 1 is granted a cycle later
    pause_at[0] = 1;
    load_msg(0, 2, 8'h11, 8'h12, 8'h00);
    push_exp(3'b001, 8'h11);
    wait_ack("t4_ack_tmo", 0, 1);
    load_msg(1, 1, 8'h21, 8'h00, 8'h00);
    push_exp(3'b010, 8'h21);
    wait_done("t4_done_tmo");
    repeat (16) @(negedge clk);
    chk("t4_no_abort_yet", 32'(bus.abort), 32'h0);
    chk("t4_grant_kept", 32'(bus.grant), 32'h1);
    @(negedge clk);
    chk("t4_abort", 32'(bus.abort), 32'h1);
    chk("t4_grant_revoked", 32'(bus.grant), 32'h0);
    @(negedge clk);
    chk("t4_abort_pulse", 32'(bus.abort), 32'h0);
    chk("t4_next_grant", 32'(bus.grant), 32'h2);
    wait_ack("t4_src1_tmo", 1, 1);
    push_exp(3'b001, 8'h12);
    pause_at[0] = -1;
    wait_idle("t4_idle_tmo");
    chk("t4_abort_count", 32'(abort_cnt), 32'd1);

    // Gap of 15 cycles: the grant is kept and the message completes
    pause_at[0] = 1;
    load_msg(0, 2, 8'h31, 8'h32, 8'h00);
    push_exp(3'b001, 8'h31);
    push_exp(3'b001, 8'h32);
    wait_ack("t4b_ack_tmo", 0, 1);
    wait_done("t4b_done_tmo");
    repeat (16) @(negedge clk);
    pause_at[0] = -1;
    wait_idle("t4b_idle_tmo");
    chk("t4b_no_abort", 32'(abort_cnt), 32'd1);

    // Busy gating: no tx_start until tx_busy falls
    force_busy = 1'b1;
    s0 = start_cnt;
    load_msg(2, 1, 8'h41, 8'h00, 8'h00);
    push_exp(3'b100, 8'h41);
    repeat (6) @(negedge clk);
    chk("t5_grant_busy", 32'(bus.grant), 32'h4);
    chk("t5_no_start_busy", 32'(start_cnt), 32'(s0));
    force_busy = 1'b0;
    @(negedge clk);
    chk("t5_start", 32'(bus.tx_start), 32'h1);
    chk("t5_data", 32'(bus.tx_data), 32'h41);
    wait_idle("t5_idle_tmo");

    // A stray tx_done while idle has no effect
    s0 = start_cnt;
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_stray_grant", 32'(bus.grant), 32'h0);
    chk("t5_stray_start", 32'(start_cnt), 32'(s0));

    // Reset during the WAIT of byte 2; afterwards requester 0 wins first
    load_msg(1, 3, 8'h51, 8'h52, 8'h53);
    push_exp(3'b010, 8'h51);
    push_exp(3'b010, 8'h52);
    wait_ack("t6_ack_tmo", 1, 2);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_grant", 32'(bus.grant), 32'h0);
    chk("t6_rst_start", 32'(bus.tx_start), 32'h0);
    chk("t6_rst_data", 32'(bus.tx_data), 32'h0);
    chk("t6_rst_ack", 32'(bus.req_ack), 32'h0);
    chk("t6_sb_empty", 32'(sb.size()), 32'h0);
    load_msg(1, 0, 8'h00, 8'h00, 8'h00);
    load_msg(2, 1, 8'h71, 8'h00, 8'h00);
    load_msg(0, 1, 8'h61, 8'h00, 8'h00);
    push_exp(3'b001, 8'h61);
    push_exp(3'b100, 8'h71);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_first_after_reset", 32'(bus.grant), 32'h1);
    wait_idle("t6_idle_tmo");

    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between N report sources, e.g. watch time report, stopwatch time report and SR04 distance report.
- Grants the transmitter to one requester for a whole message: a byte stream terminated by a last flag. Then moves to the next requester in round-robin order.
- Sits between the report formatters and the uart_tx core, in front of the uart_tx pin of the top level.

Parameters:
- N, 3, number of requesters (2..8)
- GAP_CYCLES, 16, maximum clk cycles a granted requester may hold req low between bytes before the grant is revoked
- PTR_W, 3, width of the round-robin pointer and grant index; must satisfy 2^PTR_W >= N

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- req  input  N  per-requester "byte available" level
- req_data  input  8*N  byte of requester k on bits [8k+7:8k]
- req_last  input  N  marks the presented byte as the last of the message
- req_ack  output  N  1-cycle pulse: presented byte was accepted; requester advances
- grant  output  N  one-hot owner of the transmitter, all zero when idle
- abort  output  1  1-cycle pulse when a grant is revoked by gap timeout
- tx_start  output  1  1-cycle start pulse to the uart_tx core
- tx_data  output  8  byte to the uart_tx core, held stable from tx_start until tx_done
- tx_busy  input  1  uart_tx core busy
- tx_done  input  1  1-cycle pulse at the end of the stop bit

Behaviour:
- Reset (asynchronous, rst=0):
  - State = IDLE; grant = 0; req_ack = 0; tx_start = 0; tx_data = 8'h00; abort = 0.
  - Round-robin pointer = N-1, so requester 0 wins first.
- IDLE:
  - If any req bit is high, select the first set bit scanning from pointer+1 upward, wrapping modulo N.
  - Register grant (one-hot) and go to LOAD. Arbitration costs 1 cycle.
- LOAD:
  - If req[g]=1 and tx_busy=0, in the same cycle:
    - tx_data <= req_data[g]
    - tx_start = 1 for 1 cycle
    - req_ack[g] = 1 for 1 cycle
    - latch req_last[g] into last_q
    - clear the gap counter, go to WAIT.
  - If req[g]=0, increment the gap counter.
  - When the gap counter reaches GAP_CYCLES: pulse abort, clear grant, pointer = g, go to IDLE.
- WAIT:
  - Hold grant and tx_data. Ignore all req activity.
  - On tx_done: if last_q=1, clear grant, pointer = g, go to IDLE. Otherwise go to LOAD.
  - tx_done outside WAIT is ignored.
- Latency: granted req to tx_start is 1 cycle. tx_done to the next tx_start of the same message is at least 1 cycle (LOAD).
- A grant is never pre-empted mid-message. Requests from other sources are held by their owners, never lost by the arbiter.
- A requester whose req drops and returns within GAP_CYCLES keeps the grant.
- req_ack is only ever asserted for the granted index. At most one req_ack bit is high per cycle.
- Simultaneous requests in IDLE are resolved by the pointer only. Rotation fairness: a requester waits at most N-1 messages.
- The first byte with req_last=1 ends the message, so a one-byte message has req_last=1 on its first byte.
- Reset mid-message: everything returns to the reset state immediately. The uart_tx core finishes or is reset separately; the arbiter does not wait for tx_done.

Optional Feature:
- Macro: UART_ARB_FIXED_PRIO_EN.
- Defined: IDLE selection is fixed priority, lowest index set in req wins. The pointer is not used; pointer logic may be removed.
- Not defined: round-robin as described above.
- Everything else is identical in both builds: message atomicity, gap timeout, handshake.

Test Plan:
- Single message: N=3, req[1] presents 8'h73,8'h31,8'h0A (last on 8'h0A); model core with tx_busy/tx_done, 1 byte per 10 cycles -> tx_data sequence 73,31,0A, exactly 3 req_ack[1] pulses, grant=3'b010 throughout, grant=0 one cycle after the third tx_done.
- Simultaneous requests after reset: req=3'b111, each source sends a 2-byte message -> grant order 0,1,2. No interleaving of bytes between messages.
- Fairness rotation: after serving 1, req[0] and req[2] both high -> 2 is granted before 0 (round-robin). With UART_ARB_FIXED_PRIO_EN defined -> 0 is granted.
- Gap timeout: granted requester sends 1 byte (no last), then holds req low for GAP_CYCLES=16 cycles -> abort pulse on the 16th cycle, grant=0, the next pending requester is granted 1 cycle later. A gap of 15 cycles -> no abort, message continues.
- tx_busy gating: hold tx_busy=1 on entry to LOAD -> no tx_start until tx_busy=0, then tx_start on that cycle. A stray tx_done in IDLE has no effect.
- Reset mid-message: assert rst=0 during WAIT of byte 2 -> grant=0, tx_start=0, tx_data=00 asynchronously. After release, requester 0 wins first.
